// File: rtl/sp_rd_stream.sv
// sp_rd_stream
// Streaming reader for the SuperMario chip. It generates the chip clock and
// reset, drives the configuration byte, samples the chip's byte bus on each
// rising SP_CLK, packs the bytes little-endian into OUT_W-bit words, and
// buffers the words in a show-ahead FIFO with a ready/valid output port.
//
// Ports
//   clk, nrst          system clock, asynchronous active-low reset
//   start, continuous  begin acquisition; continuous selects run-until-stop
//   stop               end continuous acquisition at the next frame end
//   din_cfg            configuration byte latched at start, driven on SP_DIN
//   dout, dout_last    FIFO head word and its end-of-frame flag
//   dout_valid/ready   output handshake (pop when both are 1)
//   busy               acquisition in progress (state is not IDLE)
//   overflow           sticky: a word was dropped because the FIFO was full
//   frame_cnt          frames completed since start
//   SP_CLK, SP_NRST    chip clock and active-low chip reset
//   SP_DIN             chip input bus
//   SP_DOUT, SP_UPDATE, SP_EOF   chip output bus, byte-valid, end-of-frame
module sp_rd_stream #(
   parameter int OUT_W      = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int CLK_DIV    = 2,
   parameter int RST_CYC    = 8
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   input  logic             continuous,
   input  logic             stop,
   input  logic [7:0]       din_cfg,
   output logic [OUT_W-1:0] dout,
   output logic             dout_last,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             overflow,
   output logic [15:0]      frame_cnt,
   output logic             SP_CLK,
   output logic             SP_NRST,
   output logic [7:0]       SP_DIN,
   input  logic [7:0]       SP_DOUT,
   input  logic             SP_UPDATE,
   input  logic             SP_EOF
);

   localparam int NB = OUT_W / 8;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [3:0]  LAST_BYTE = 4'(NB - 1);
   localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
   localparam logic [15:0] RST_LAST  = 16'((RST_CYC > 0) ? RST_CYC - 1 : 0);
   localparam logic [AW:0] DEPTH_W   = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, CRST, RUN, DRAIN} state_t;

   state_t           state;
   logic             cont_q;
   logic             stop_q;
   logic [15:0]      rst_cnt;
   logic [15:0]      div_cnt;
   logic [3:0]       byte_idx;
   logic [OUT_W-1:0] pack_word;
   logic             push_valid;
   logic             push_last;
   logic [OUT_W-1:0] push_data;

   logic [OUT_W:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [OUT_W:0]   head;

   logic             sample_pt;
   logic             upd_beat;
   logic             frame_end;
   logic             full;
   logic             pop;
   logic             do_write;
   logic [OUT_W-1:0] merged;

   // The sample point is the clk cycle whose closing edge drives SP_CLK
   // from 0 to 1; the chip bus is captured on that same edge.
   assign sample_pt = (state == RUN) && !SP_CLK && (div_cnt == DIV_LAST);
   assign upd_beat  = sample_pt && SP_UPDATE;
   assign frame_end = upd_beat && SP_EOF;
   assign merged    = pack_word | (OUT_W'(SP_DOUT) << (8 * byte_idx));

   assign busy       = (state != IDLE);
   assign dout_valid = (count != '0);
   assign full       = (count == DEPTH_W);
   assign pop        = dout_valid && dout_ready;
   // A push into a full FIFO still lands if the head leaves on the same edge.
   assign do_write   = push_valid && (!full || pop);
   assign head       = mem[rd_ptr];
   assign dout       = dout_valid ? head[OUT_W-1:0] : '0;
   assign dout_last  = dout_valid && head[OUT_W];

   // Acquisition sequencer: chip reset, chip clock divider, byte packer and
   // frame accounting. A completed word is staged in push_* for one cycle
   // and written into the FIFO on the following edge. DRAIN also waits for
   // that staged word so the final word of a frame is never left behind.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= IDLE;
         cont_q     <= 1'b0;
         stop_q     <= 1'b0;
         rst_cnt    <= '0;
         div_cnt    <= '0;
         byte_idx   <= '0;
         pack_word  <= '0;
         push_valid <= 1'b0;
         push_last  <= 1'b0;
         push_data  <= '0;
         frame_cnt  <= '0;
         SP_CLK     <= 1'b0;
         SP_NRST    <= 1'b0;
         SP_DIN     <= '0;
      end else begin
         push_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cont_q    <= continuous;
                  SP_DIN    <= din_cfg;
                  stop_q    <= 1'b0;
                  frame_cnt <= '0;
                  pack_word <= '0;
                  byte_idx  <= '0;
                  rst_cnt   <= '0;
                  state     <= CRST;
               end
            end
            CRST: begin
               if (rst_cnt == RST_LAST) begin
                  SP_NRST <= 1'b1;
                  SP_CLK  <= 1'b0;
                  div_cnt <= '0;
                  state   <= RUN;
               end else begin
                  rst_cnt <= rst_cnt + 16'd1;
               end
            end
            RUN: begin
               if (stop) begin
                  stop_q <= 1'b1;
               end
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  SP_CLK  <= ~SP_CLK;
               end else begin
                  div_cnt <= div_cnt + 16'd1;
               end
               if (upd_beat) begin
                  if (SP_EOF || (byte_idx == LAST_BYTE)) begin
                     push_valid <= 1'b1;
                     push_data  <= merged;
                     push_last  <= SP_EOF;
                     pack_word  <= '0;
                     byte_idx   <= '0;
                  end else begin
                     pack_word <= merged;
                     byte_idx  <= byte_idx + 4'd1;
                  end
               end
               // A stop arriving on the frame-end cycle itself still counts.
               if (frame_end) begin
                  frame_cnt <= frame_cnt + 16'd1;
                  if (!cont_q || stop_q || stop) begin
                     SP_CLK <= 1'b0;
                     state  <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (!push_valid && (count == '0)) begin
                  SP_NRST <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO pointers, occupancy and the sticky overflow flag. Overflow is
   // cleared only when a new acquisition starts.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_write, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if ((state == IDLE) && start) begin
            overflow <= 1'b0;
         end else if (push_valid && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   // FIFO storage; contents need no reset because the pointers define
   // which entries are live and the outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr] <= {push_last, push_data};
      end
   end

endmodule

// File: tb/tb_sp_rd_stream.sv
// tb_sp_rd_stream
// Self-checking bench for sp_rd_stream (OUT_W=32, FIFO_DEPTH=4, CLK_DIV=2,
// RST_CYC=8). A chip model feeds queued byte beats, advancing one beat per
// rising SP_CLK; a consumer pops words under a selectable ready policy and
// compares them with words predicted by chunking each frame into 4-byte
// little-endian groups.
module tb_sp_rd_stream;

   localparam int OUT_W      = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int CLK_DIV    = 2;
   localparam int RST_CYC    = 8;
   localparam int NB         = OUT_W / 8;
   localparam int BUDGET     = 4000;

   typedef struct packed {
      logic       upd;
      logic       eof;
      logic [7:0] data;
   } beat_t;

   logic             clk = 1'b0;
   logic             nrst = 1'b0;
   logic             start = 1'b0;
   logic             continuous = 1'b0;
   logic             stop = 1'b0;
   logic [7:0]       din_cfg = 8'd0;
   logic [OUT_W-1:0] dout;
   logic             dout_last;
   logic             dout_valid;
   logic             dout_ready;
   logic             busy;
   logic             overflow;
   logic [15:0]      frame_cnt;
   logic             SP_CLK;
   logic             SP_NRST;
   logic [7:0]       SP_DIN;
   logic [7:0]       SP_DOUT;
   logic             SP_UPDATE;
   logic             SP_EOF;

   beat_t            beatQ[$];
   logic [OUT_W:0]   expQ[$];
   logic [7:0]       frameBytes[$];
   int               assertCount = 0;
   int               failCount = 0;
   int               readyMode = 1;
   bit               oneShotDone = 1'b0;

   sp_rd_stream #(
      .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV), .RST_CYC(RST_CYC)
   ) dut (
      .clk(clk), .nrst(nrst), .start(start), .continuous(continuous), .stop(stop),
      .din_cfg(din_cfg), .dout(dout), .dout_last(dout_last), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .busy(busy), .overflow(overflow), .frame_cnt(frame_cnt),
      .SP_CLK(SP_CLK), .SP_NRST(SP_NRST), .SP_DIN(SP_DIN), .SP_DOUT(SP_DOUT),
      .SP_UPDATE(SP_UPDATE), .SP_EOF(SP_EOF)
   );

   // 100 MHz system clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Fill frameBytes with n bytes, either random or base, base+1, ...
   task automatic fillBytes(input int n, input logic [7:0] base, input bit rnd);
      frameBytes.delete();
      for (int i = 0; i < n; i++) begin
         frameBytes.push_back(rnd ? 8'($urandom) : base + 8'(i));
      end
   endtask

   // Queue frameBytes as chip beats (optionally with idle beats, some of
   // which carry a stray EOF) and, if modelled, the words it must produce.
   task automatic addFrame(input bit modelIt, input bit withGaps);
      logic [OUT_W-1:0] word;
      beat_t            b;
      int               n;
      word = '0;
      n = frameBytes.size();
      for (int i = 0; i < n; i++) begin
         if (withGaps && ($urandom_range(0, 3) == 0)) begin
            b.upd  = 1'b0;
            b.eof  = 1'($urandom_range(0, 1));
            b.data = 8'($urandom);
            beatQ.push_back(b);
         end
         b.upd  = 1'b1;
         b.eof  = (i == n - 1);
         b.data = frameBytes[i];
         beatQ.push_back(b);
         if (modelIt) begin
            word[8*(i%NB) +: 8] = frameBytes[i];
            if (((i % NB) == NB - 1) || (i == n - 1)) begin
               expQ.push_back({(i == n - 1), word});
               word = '0;
            end
         end
      end
   endtask

   // Start an acquisition and check busy, the chip reset length and the
   // first SP_CLK rise. A second start during CRST must be ignored.
   task automatic applyStimulus(input bit cont, input logic [7:0] cfg);
      @(negedge clk);
      checkOutput("idle_before_start", 64'(busy), 64'd0);
      continuous = cont;
      din_cfg = cfg;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_after_start", 64'(busy), 64'd1);
      start = 1'b1;
      continuous = ~cont;
      din_cfg = ~cfg;
      @(negedge clk);
      start = 1'b0;
      continuous = cont;
      din_cfg = cfg;
      repeat (RST_CYC - 2) @(negedge clk);
      checkOutput("sp_nrst_still_low", 64'(SP_NRST), 64'd0);
      @(negedge clk);
      checkOutput("sp_nrst_rise", 64'(SP_NRST), 64'd1);
      repeat (CLK_DIV - 1) @(negedge clk);
      checkOutput("sp_clk_low_start", 64'(SP_CLK), 64'd0);
      @(negedge clk);
      checkOutput("sp_clk_first_rise", 64'(SP_CLK), 64'd1);
   endtask

   // Wait until idle (untilIdle) or until frame_cnt reaches target, pulsing
   // stop once during frame stopAtFrame when it is non-zero.
   task automatic runUntil(input int target, input int stopAtFrame, input bit untilIdle);
      bit stopped;
      bit done;
      stopped = 1'b0;
      done = 1'b0;
      for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
         stop = 1'b0;
         if (untilIdle ? !busy : (frame_cnt == 16'(target))) begin
            done = 1'b1;
         end else begin
            if ((stopAtFrame > 0) && !stopped && SP_NRST && (frame_cnt == 16'(stopAtFrame - 1))) begin
               stop = 1'b1;
               stopped = 1'b1;
            end
            @(negedge clk);
         end
      end
      stop = 1'b0;
      if (!done) begin
         checkOutput("wait_timeout", 64'(frame_cnt), 64'(target));
      end
   endtask

   // Post-run checks, then discard leftover beats and predictions.
   task automatic endChecks(input int frames, input bit ovf, input logic [7:0] cfg);
      checkOutput("frame_cnt", 64'(frame_cnt), 64'(frames));
      checkOutput("overflow", 64'(overflow), 64'(ovf));
      checkOutput("sp_din", 64'(SP_DIN), 64'(cfg));
      checkOutput("sp_nrst_idle", 64'(SP_NRST), 64'd0);
      checkOutput("sp_clk_idle", 64'(SP_CLK), 64'd0);
      checkOutput("fifo_empty", 64'(dout_valid), 64'd0);
      checkOutput("words_missing", 64'(expQ.size()), 64'd0);
      beatQ.delete();
      expQ.delete();
   endtask

   // Chip model: idle while in reset, presents the first beat when reset is
   // released, then moves to the next beat after every SP_CLK rise.
   initial begin
      bit    active;
      logic  prevClk;
      beat_t b;
      active = 1'b0;
      prevClk = 1'b0;
      SP_DOUT = 8'd0;
      SP_UPDATE = 1'b0;
      SP_EOF = 1'b0;
      forever begin
         @(negedge clk);
         if (!SP_NRST) begin
            active = 1'b0;
            SP_UPDATE = 1'b0;
            SP_EOF = 1'b0;
         end else if (!active || (!prevClk && SP_CLK)) begin
            active = 1'b1;
            if (beatQ.size() > 0) begin
               b = beatQ.pop_front();
               SP_UPDATE = b.upd;
               SP_EOF = b.eof;
               SP_DOUT = b.data;
            end else begin
               SP_UPDATE = 1'b0;
               SP_EOF = 1'b0;
               SP_DOUT = 8'($urandom);
            end
         end
         prevClk = SP_CLK;
      end
   end

   // Consumer: chooses dout_ready for the next edge and checks each popped
   // word against the prediction queue. Mode 3 asserts ready for exactly
   // the first cycle in which frame_cnt reads 1.
   initial begin
      logic           rdy;
      logic [OUT_W:0] expWord;
      dout_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (readyMode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            2:       rdy = ($urandom_range(0, 3) != 0);
            default: begin
               rdy = !oneShotDone && (frame_cnt == 16'd1);
               if (rdy) oneShotDone = 1'b1;
            end
         endcase
         dout_ready = rdy;
         if (rdy && dout_valid && nrst) begin
            if (expQ.size() > 0) begin
               expWord = expQ.pop_front();
               checkOutput("word", 64'({dout_last, dout}), 64'(expWord));
            end else begin
               checkOutput("unexpected_word", 64'(dout_valid), 64'd0);
            end
         end
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset values, directed scenarios, then random runs.
   initial begin
      logic [7:0] cfg;
      bit         cont;
      int         nFrames;
      bit         seen;

      nrst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_sp_nrst", 64'(SP_NRST), 64'd0);
      checkOutput("rst_sp_clk", 64'(SP_CLK), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_dout_valid", 64'(dout_valid), 64'd0);
      checkOutput("rst_dout", 64'({dout_last, dout}), 64'd0);
      checkOutput("rst_overflow", 64'(overflow), 64'd0);
      checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      checkOutput("rst_sp_din", 64'(SP_DIN), 64'd0);
      nrst = 1'b1;
      @(negedge clk);

      $display("[TB] single 4-byte frame");
      readyMode = 1;
      frameBytes.delete();
      frameBytes.push_back(8'h11);
      frameBytes.push_back(8'h22);
      frameBytes.push_back(8'h33);
      frameBytes.push_back(8'h44);
      addFrame(1'b1, 1'b0);
      applyStimulus(1'b0, 8'hA5);
      runUntil(0, 0, 1'b1);
      endChecks(1, 1'b0, 8'hA5);

      $display("[TB] partial final word");
      fillBytes(6, 8'h01, 1'b0);
      addFrame(1'b1, 1'b1);
      applyStimulus(1'b0, 8'h3C);
      runUntil(0, 0, 1'b1);
      endChecks(1, 1'b0, 8'h3C);

      $display("[TB] backpressure and overflow");
      readyMode = 0;
      fillBytes(24, 8'h00, 1'b1);
      addFrame(1'b1, 1'b1);
      while (expQ.size() > FIFO_DEPTH) void'(expQ.pop_back());
      applyStimulus(1'b0, 8'h5A);
      runUntil(1, 0, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("bp_overflow", 64'(overflow), 64'd1);
      checkOutput("bp_valid", 64'(dout_valid), 64'd1);
      checkOutput("bp_head", 64'({dout_last, dout}), 64'(expQ[0]));
      checkOutput("bp_busy_drain", 64'(busy), 64'd1);
      readyMode = 1;
      runUntil(0, 0, 1'b1);
      endChecks(1, 1'b1, 8'h5A);

      $display("[TB] continuous with stop in frame 2");
      readyMode = 2;
      for (int f = 0; f < 3; f++) begin
         fillBytes(8, 8'h00, 1'b1);
         addFrame(f < 2, 1'b1);
      end
      applyStimulus(1'b1, 8'hC3);
      runUntil(2, 2, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 4 * CLK_DIV + 2; i++) begin
         @(negedge clk);
         if (SP_CLK) seen = 1'b1;
      end
      checkOutput("sp_clk_held_after_stop", 64'(seen), 64'd0);
      runUntil(0, 0, 1'b1);
      endChecks(2, 1'b0, 8'hC3);

      $display("[TB] full FIFO with simultaneous push and pop");
      oneShotDone = 1'b0;
      readyMode = 3;
      fillBytes(20, 8'h00, 1'b1);
      addFrame(1'b1, 1'b1);
      applyStimulus(1'b0, 8'h99);
      runUntil(1, 0, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("simul_overflow", 64'(overflow), 64'd0);
      checkOutput("simul_head", 64'({dout_last, dout}), 64'(expQ[0]));
      readyMode = 1;
      runUntil(0, 0, 1'b1);
      endChecks(1, 1'b0, 8'h99);

      $display("[TB] reset during run");
      readyMode = 0;
      fillBytes(24, 8'h00, 1'b1);
      addFrame(1'b1, 1'b1);
      addFrame(1'b0, 1'b1);
      applyStimulus(1'b1, 8'h77);
      seen = 1'b0;
      for (int cyc = 0; cyc < BUDGET && !seen; cyc++) begin
         @(negedge clk);
         seen = overflow;
      end
      checkOutput("pre_reset_overflow", 64'(overflow), 64'd1);
      nrst = 1'b0;
      #1;
      checkOutput("mid_rst_sp_nrst", 64'(SP_NRST), 64'd0);
      checkOutput("mid_rst_valid", 64'(dout_valid), 64'd0);
      checkOutput("mid_rst_busy", 64'(busy), 64'd0);
      checkOutput("mid_rst_overflow", 64'(overflow), 64'd0);
      checkOutput("mid_rst_sp_din", 64'(SP_DIN), 64'd0);
      @(negedge clk);
      beatQ.delete();
      expQ.delete();
      nrst = 1'b1;
      readyMode = 1;
      fillBytes(7, 8'h00, 1'b1);
      addFrame(1'b1, 1'b1);
      applyStimulus(1'b0, 8'h42);
      runUntil(0, 0, 1'b1);
      endChecks(1, 1'b0, 8'h42);

      $display("[TB] randomized runs");
      for (int iter = 0; iter < 8; iter++) begin
         readyMode = 2;
         cont = 1'($urandom_range(0, 1));
         nFrames = cont ? $urandom_range(2, 3) : 1;
         cfg = 8'($urandom);
         for (int f = 0; f < nFrames; f++) begin
            fillBytes($urandom_range(1, 20), 8'h00, 1'b1);
            addFrame(1'b1, 1'b1);
         end
         fillBytes(4, 8'h00, 1'b1);
         addFrame(1'b0, 1'b1);
         applyStimulus(cont, cfg);
         runUntil(0, cont ? nFrames : 0, 1'b1);
         endChecks(nFrames, 1'b0, cfg);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
